misaligned_lsu: RTL and testbench
=================================

Name: misaligned_lsu

Overview:
- Load/store unit between the core's execute stage and the byte-enabled word data memory.
- Decodes RV32I load/store width from funct3 and converts byte addresses into a word address, byte enables and lane-shifted store data.
- Splits word-crossing (misaligned) accesses into two sequential memory accesses.
- Assembles and sign/zero-extends load results, then returns one registered response per request.

Parameters:
- ADDR_BITS, 16: byte-address bits implemented. Memory word address is ADDR_BITS-2 bits wide; req_addr bits above ADDR_BITS-1 are ignored.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I load/store funct3
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  load result; 0 for stores and errors
- resp_err  output  1  illegal funct3, qualified by resp_valid
- mem_address  output  ADDR_BITS-2  word address
- mem_byteena  output  4  byte enables
- mem_data  output  32  lane-aligned write data
- mem_wren  output  1  write strobe
- mem_q  input  32  combinational read data for mem_address

Behaviour:
- Reset
  - reset==0 at a rising edge sends the FSM to IDLE.
  - Registered outputs clear: resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_wren=0, mem_byteena=0, mem_address=0, mem_data=0.
  - Reset overrides everything, including mid-operation.
  - If reset lands in ACC2 of a split store, the first half is already written and stays (no rollback); the second half is never issued.
- FSM states: IDLE, ACC1, ACC2, RESP.
  - req_ready=1 only in IDLE.
  - IDLE: on req_valid, latch we/funct3/addr/wdata and go to ACC1.
  - ACC1: drive the first memory access. If the access crosses a word boundary, go to ACC2; otherwise go to RESP.
  - ACC2: drive the second access, then go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - An illegal funct3 goes IDLE -> RESP directly: no memory access, resp_err=1, resp_rdata=0.
- Latency
  - Request accepted at edge T.
  - Aligned/non-crossing: resp_valid high in cycle T+2.
  - Crossing: resp_valid high in cycle T+3.
  - Illegal funct3: resp_valid high in cycle T+1.
  - Throughput: one request per 3 cycles (aligned) or 4 cycles (crossing).
- Decode
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other funct3 encodings for the given req_we are illegal.
- Address split
  - off = addr[1:0]; w = addr[ADDR_BITS-1:2]; size mask m = 0001 / 0011 / 1111.
  - crossing = (half && off==3) || (word && off!=0).
  - ACC1: mem_address=w, mem_byteena=(m<<off)[3:0], mem_data=wdata<<(8*off).
  - ACC2: mem_address=w+1 (wraps modulo 2^(ADDR_BITS-2)), mem_byteena=m>>(4-off), mem_data=wdata>>(8*(4-off)).
  - mem_wren=we in ACC1/ACC2; mem_wren=0 otherwise.
  - Outside ACC1/ACC2, mem_byteena=0.
  - Memory outputs are driven from registered state only (no combinational path from req_*).
- Load assembly
  - ACC1 captures mem_q>>(8*off).
  - ACC2 ORs in mem_q<<(8*(4-off)).
  - Result is truncated to size, then sign-extended (LB/LH) or zero-extended (LBU/LHU/LW) into resp_rdata.
  - Loads drive byteena for the accessed lanes with mem_wren=0.
- Store response: resp_rdata=0, resp_err=0.
- req_valid outside IDLE is ignored; the requester holds the request until it sees req_ready=1.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, then LW 0x100:
  - SW: ACC1 mem_address=0x40, byteena=1111, wren=1.
  - LW: resp_rdata=0xDEADBEEF, resp_valid exactly 2 cycles after acceptance.
- After the above, LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD; LHU 0x100 -> 0x0000BEEF.
- SW 0x104 data 0x33221100, then LW 0x102:
  - LW accesses word 0x40 with byteena 1100, then word 0x41 with byteena 0011.
  - resp_rdata=0x1100DEAD, 3 cycles after acceptance.
- SH 0x107 data 0x00001234:
  - ACC1: word 0x41, byteena 1000, mem_data[31:24]=0x34.
  - ACC2: word 0x42, byteena 0001, mem_data[7:0]=0x12.
  - LH 0x107 -> 0x00001234.
- Wrap: SW 0xFFFE data 0xAABBCCDD (ADDR_BITS=16):
  - ACC1: word 0x3FFF, byteena 1100.
  - ACC2: word 0x0000, byteena 0011.
  - LW 0xFFFE -> 0xAABBCCDD.
- Error and reset:
  - Load funct3=011 -> resp_valid 1 cycle after acceptance, resp_err=1, mem_wren never asserted.
  - Split SW with reset=0 during ACC2 -> no ACC2 write, resp_valid never pulses, req_ready=1 the cycle after reset releases.

Source files
------------

// File: rtl/misaligned_lsu.sv
// RV32I load/store unit: decodes width, lane-shifts data and splits word-crossing
// accesses into two back-to-back accesses on a byte-enabled word memory.
module misaligned_lsu #(
    parameter int unsigned ADDR_BITS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [ADDR_BITS-3:0] mem_address,
    output logic [3:0]           mem_byteena,
    output logic [31:0]          mem_data,
    output logic                 mem_wren,
    input  logic [31:0]          mem_q
);

    localparam int unsigned AW = ADDR_BITS - 2;

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t         state_q, state_d;
    logic           req_ready_q, req_ready_d;
    logic           we_q, we_d;
    logic [2:0]     f3_q, f3_d;
    logic [1:0]     off_q, off_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    acc_q, acc_d;
    logic           resp_valid_q, resp_valid_d;
    logic [31:0]    resp_rdata_q, resp_rdata_d;
    logic           resp_err_q, resp_err_d;
    logic [AW-1:0]  mem_address_q, mem_address_d;
    logic [3:0]     mem_byteena_q, mem_byteena_d;
    logic [31:0]    mem_data_q, mem_data_d;
    logic           mem_wren_q, mem_wren_d;

    logic [7:0]     req_be_wide;
    logic [4:0]     sh_lo, sh_hi;
    logic [31:0]    load_first, load_both;
    logic           unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_BITS];

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic crosses(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && (off == 2'd3)) ||
               ((f3[1:0] == 2'b10) && (off != 2'd0));
    endfunction

    // Truncate to access size, then sign- or zero-extend (funct3[2] marks unsigned)
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] x);
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'h0, x[7:0]}  : {{24{x[7]}}, x[7:0]};
            2'b01:   return f3[2] ? {16'h0, x[15:0]} : {{16{x[15]}}, x[15:0]};
            default: return x;
        endcase
    endfunction

    assign req_be_wide = {4'b0000, size_mask(req_funct3)} << req_addr[1:0];
    assign sh_lo       = {off_q, 3'b000};
    assign sh_hi       = 5'(6'd32 - {1'b0, off_q, 3'b000});
    assign load_first  = mem_q >> sh_lo;
    assign load_both   = acc_q | (mem_q << sh_hi);

    // Next-state and next-output logic; memory strobes are registered one state early
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        f3_d          = f3_q;
        off_d         = off_q;
        wdata_d       = wdata_q;
        acc_d         = acc_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        mem_address_d = mem_address_q;
        mem_byteena_d = 4'b0000;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    acc_d   = 32'h0;
                    if (is_legal(req_we, req_funct3)) begin
                        state_d       = ACC1;
                        mem_address_d = req_addr[ADDR_BITS-1:2];
                        mem_byteena_d = req_be_wide[3:0];
                        mem_data_d    = req_wdata << {req_addr[1:0], 3'b000};
                        mem_wren_d    = req_we;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end
                end
            end
            ACC1: begin
                if (crosses(f3_q, off_q)) begin
                    state_d       = ACC2;
                    acc_d         = load_first;
                    mem_address_d = AW'(mem_address_q + 1'b1);
                    mem_byteena_d = size_mask(f3_q) >> (3'd4 - {1'b0, off_q});
                    mem_data_d    = wdata_q >> sh_hi;
                    mem_wren_d    = we_q;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = we_q ? 32'h0 : extend(f3_q, load_first);
                end
            end
            ACC2: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = we_q ? 32'h0 : extend(f3_q, load_both);
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            we_q          <= 1'b0;
            f3_q          <= 3'b000;
            off_q         <= 2'b00;
            wdata_q       <= 32'h0;
            acc_q         <= 32'h0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'h0;
            resp_err_q    <= 1'b0;
            mem_address_q <= '0;
            mem_byteena_q <= 4'b0000;
            mem_data_q    <= 32'h0;
            mem_wren_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            we_q          <= we_d;
            f3_q          <= f3_d;
            off_q         <= off_d;
            wdata_q       <= wdata_d;
            acc_q         <= acc_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            mem_address_q <= mem_address_d;
            mem_byteena_q <= mem_byteena_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_address = mem_address_q;
    assign mem_byteena = mem_byteena_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;

endmodule

// File: tb/tb_misaligned_lsu.sv
// Directed bench for misaligned_lsu against a byte-enabled word memory model.
module tb_misaligned_lsu;

    localparam int unsigned ADDR_BITS = 16;
    localparam int unsigned AW        = ADDR_BITS - 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteena;
    logic [31:0]   mem_data;
    logic          mem_wren;
    logic [31:0]   mem_q;

    logic [31:0]   mem [0:(1<<AW)-1] = '{default: 32'h0};

    int            n_checks = 0;
    int            n_fail   = 0;

    // Memory accesses observed during the most recent request
    int            nacc;
    logic [31:0]   acc_addr [0:3];
    logic [31:0]   acc_be   [0:3];
    logic [31:0]   acc_wren [0:3];
    logic [31:0]   acc_data [0:3];

    int            lat;
    logic [31:0]   rd;
    logic          err;

    misaligned_lsu #(.ADDR_BITS(ADDR_BITS)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_address (mem_address),
        .mem_byteena (mem_byteena),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    always #5 clock = ~clock;

    assign mem_q = mem[mem_address];

    always @(posedge clock) begin
        if (mem_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byteena[b]) mem[mem_address][8*b +: 8] <= mem_data[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, record accesses, and return response latency (0 = timeout)
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clock);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        for (int k = 0; k < 10 && !req_ready; k++) @(negedge clock);
        @(posedge clock);
        #1 req_valid = 1'b0;
        nacc = 0;
        lat  = 0;
        rd   = 32'hxxxxxxxx;
        err  = 1'bx;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            if ((mem_byteena != 4'b0 || mem_wren) && nacc < 4) begin
                acc_addr[nacc] = 32'(mem_address);
                acc_be[nacc]   = 32'(mem_byteena);
                acc_wren[nacc] = 32'(mem_wren);
                acc_data[nacc] = mem_data;
                nacc++;
            end
            if (resp_valid) begin
                lat = n;
                rd  = resp_rdata;
                err = resp_err;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input int exp_lat);
        do_req(we, f3, addr, wdata);
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/rdata"}, rd, exp_rd);
        chk({tag, "/err"}, 32'(err), 32'(0));
        chk({tag, "/naccess"}, 32'(nacc), (exp_lat == 3) ? 32'd2 : 32'd1);
    endtask

    task automatic chk_acc(input string tag, input int i, input logic [31:0] a,
                           input logic [31:0] be, input logic [31:0] wr, input logic [31:0] d,
                           input logic chk_data);
        chk({tag, "/addr"}, acc_addr[i], a);
        chk({tag, "/byteena"}, acc_be[i], be);
        chk({tag, "/wren"}, acc_wren[i], wr);
        if (chk_data) chk({tag, "/data"}, acc_data[i], d);
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst/req_ready", 32'(req_ready), 32'd1);
        chk("rst/resp_valid", 32'(resp_valid), 32'd0);
        chk("rst/resp_rdata", resp_rdata, 32'h0);
        chk("rst/resp_err", 32'(resp_err), 32'd0);
        chk("rst/mem_wren", 32'(mem_wren), 32'd0);
        chk("rst/mem_byteena", 32'(mem_byteena), 32'd0);
        chk("rst/mem_address", 32'(mem_address), 32'd0);
        chk("rst/mem_data", mem_data, 32'h0);

        // Aligned word store then reload
        run("sw100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2);
        chk_acc("sw100/a1", 0, 32'h40, 32'hF, 32'd1, 32'hDEADBEEF, 1'b1);
        run("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        chk_acc("lw100/a1", 0, 32'h40, 32'hF, 32'd0, 32'h0, 1'b0);

        // Sub-word loads with sign/zero extension
        run("lb103", 1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFFDE, 2);
        chk_acc("lb103/a1", 0, 32'h40, 32'h8, 32'd0, 32'h0, 1'b0);
        run("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h000000DE, 2);
        run("lh102", 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFFDEAD, 2);
        run("lhu100", 1'b0, 3'b101, 32'h100, 32'h0, 32'h0000BEEF, 2);

        // Word-crossing load
        run("sw104", 1'b1, 3'b010, 32'h104, 32'h33221100, 32'h0, 2);
        run("lw102", 1'b0, 3'b010, 32'h102, 32'h0, 32'h1100DEAD, 3);
        chk_acc("lw102/a1", 0, 32'h40, 32'hC, 32'd0, 32'h0, 1'b0);
        chk_acc("lw102/a2", 1, 32'h41, 32'h3, 32'd0, 32'h0, 1'b0);

        // Word-crossing halfword store
        run("sh107", 1'b1, 3'b001, 32'h107, 32'h00001234, 32'h0, 3);
        chk_acc("sh107/a1", 0, 32'h41, 32'h8, 32'd1, 32'h34000000, 1'b1);
        chk_acc("sh107/a2", 1, 32'h42, 32'h1, 32'd1, 32'h00000012, 1'b1);
        run("lh107", 1'b0, 3'b001, 32'h107, 32'h0, 32'h00001234, 3);

        // Address wrap at top of memory
        run("swfffe", 1'b1, 3'b010, 32'hFFFE, 32'hAABBCCDD, 32'h0, 3);
        chk_acc("swfffe/a1", 0, 32'h3FFF, 32'hC, 32'd1, 32'hCCDD0000, 1'b1);
        chk_acc("swfffe/a2", 1, 32'h0000, 32'h3, 32'd1, 32'h0000AABB, 1'b1);
        run("lwfffe", 1'b0, 3'b010, 32'hFFFE, 32'h0, 32'hAABBCCDD, 3);

        // Illegal funct3 for load and for store
        do_req(1'b0, 3'b011, 32'h100, 32'h0);
        chk("ill_ld/latency", 32'(lat), 32'd1);
        chk("ill_ld/err", 32'(err), 32'd1);
        chk("ill_ld/rdata", rd, 32'h0);
        chk("ill_ld/naccess", 32'(nacc), 32'd0);
        do_req(1'b1, 3'b100, 32'h100, 32'h12345678);
        chk("ill_st/latency", 32'(lat), 32'd1);
        chk("ill_st/err", 32'(err), 32'd1);
        chk("ill_st/naccess", 32'(nacc), 32'd0);
        chk("ill_st/mem40", mem[14'h40], 32'hDEADBEEF);

        // Reset lands as the split store heads into its second access
        @(negedge clock);
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h201;
        req_wdata  = 32'h55667788;
        req_valid  = 1'b1;
        for (int k = 0; k < 10 && !req_ready; k++) @(negedge clock);
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        chk("rstmid/a1_byteena", 32'(mem_byteena), 32'hE);
        chk("rstmid/a1_wren", 32'(mem_wren), 32'd1);
        chk("rstmid/a1_data", mem_data, 32'h66778800);
        reset = 1'b0;
        @(negedge clock);
        chk("rstmid/wren_in_rst", 32'(mem_wren), 32'd0);
        chk("rstmid/be_in_rst", 32'(mem_byteena), 32'd0);
        chk("rstmid/rv_in_rst", 32'(resp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rstmid/req_ready", 32'(req_ready), 32'd1);
        chk("rstmid/rv_after", 32'(resp_valid), 32'd0);
        chk("rstmid/wren_after", 32'(mem_wren), 32'd0);
        chk("rstmid/mem80", mem[14'h80], 32'h66778800);
        chk("rstmid/mem81", mem[14'h81], 32'h0);
        run("lw200", 1'b0, 3'b010, 32'h200, 32'h0, 32'h66778800, 2);
        run("lw204", 1'b0, 3'b010, 32'h204, 32'h0, 32'h00000000, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
